// File: rtl/mic_seq_pkg.sv
// Shared types and widths for the microphone frame sequencer.
package mic_seq_pkg;

  typedef enum logic {
    StIdle,
    StSend
  } ser_state_e;

  localparam int unsigned FrameCountWidth   = 16;
  localparam int unsigned OverrunCountWidth = 8;

  function automatic int unsigned chan_width(input int unsigned num_chan);
    return (num_chan <= 2) ? 1 : $clog2(num_chan);
  endfunction

endpackage

// File: rtl/mic_seq_serializer.sv
// Output frame buffer and IDLE/SEND stream FSM; emits one channel per handshake.
module mic_seq_serializer
  import mic_seq_pkg::*;
#(
  parameter int unsigned NumChan   = 8,
  parameter int unsigned DataWidth = 24,
  parameter int unsigned ChanWidth = chan_width(NumChan)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_frame_valid,
  input  logic [NumChan*DataWidth-1:0]   i_frame,
  output logic                           o_take,
  output logic [DataWidth-1:0]           o_data,
  output logic [ChanWidth-1:0]           o_chan,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic                           o_last,
  output logic [FrameCountWidth-1:0]     o_frame_count
);

  ser_state_e                     r_state;
  logic [NumChan*DataWidth-1:0]   r_buf;
  logic [DataWidth-1:0]           r_data;
  logic [ChanWidth-1:0]           r_chan;
  logic                           r_valid;
  logic                           r_last;
  logic [FrameCountWidth-1:0]     r_frame_count;

  logic                           w_fire;
  logic                           w_end;
  logic [ChanWidth-1:0]           w_next;

  assign w_fire = r_valid && i_ready;
  assign w_end  = w_fire && r_last;
  assign w_next = r_chan + 1'b1;
  // A waiting frame is taken on the final beat so back-to-back frames have no gap.
  assign o_take = i_frame_valid && ((r_state == StIdle) || w_end);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= StIdle;
      r_buf         <= '0;
      r_data        <= '0;
      r_chan        <= '0;
      r_valid       <= 1'b0;
      r_last        <= 1'b0;
      r_frame_count <= '0;
    end else begin
      if (w_end) begin
        r_frame_count <= r_frame_count + 1'b1;
      end
      if (o_take) begin
        r_state <= StSend;
        r_buf   <= i_frame;
        r_valid <= 1'b1;
        r_chan  <= '0;
        r_data  <= i_frame[DataWidth-1:0];
        r_last  <= 1'b0;
      end else if (w_end) begin
        r_state <= StIdle;
        r_valid <= 1'b0;
        r_last  <= 1'b0;
        r_chan  <= '0;
      end else if (w_fire) begin
        r_chan <= w_next;
        r_data <= r_buf[w_next*DataWidth +: DataWidth];
        r_last <= (w_next == ChanWidth'(NumChan - 1));
      end
    end
  end

  assign o_data        = r_data;
  assign o_chan        = r_chan;
  assign o_valid       = r_valid;
  assign o_last        = r_last;
  assign o_frame_count = r_frame_count;

endmodule

// File: rtl/mic_frame_sequencer.sv
// Aligns per-receiver I2S samples into array frames and streams them channel by channel.
// Optional skew timeout flush is built when MIC_SEQ_SKEW_TIMEOUT_EN is defined.
module mic_frame_sequencer
  import mic_seq_pkg::*;
#(
  parameter int unsigned NUM_RX       = 4,
  parameter int unsigned DATA_WIDTH   = 24,
  parameter int unsigned SKEW_TIMEOUT = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_RX-1:0]                  rx_valid,
  input  logic [NUM_RX*DATA_WIDTH-1:0]       rx_left,
  input  logic [NUM_RX*DATA_WIDTH-1:0]       rx_right,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic [chan_width(2*NUM_RX)-1:0]    out_chan,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_last,
  output logic [FrameCountWidth-1:0]         frame_count,
  output logic [OverrunCountWidth-1:0]       overrun_count,
  output logic                               skew_err
);

  localparam int unsigned NumChan   = 2 * NUM_RX;
  localparam int unsigned ChanWidth = chan_width(NumChan);

  logic [NUM_RX*DATA_WIDTH-1:0]   r_left;
  logic [NUM_RX*DATA_WIDTH-1:0]   r_right;
  logic [NUM_RX-1:0]              r_pending;
  logic [OverrunCountWidth-1:0]   r_overrun;

  logic [NUM_RX-1:0]              w_pending_d;
  logic [15:0]                    w_ovr_sum;
  logic [NumChan*DATA_WIDTH-1:0]  w_frame;
  logic                           w_complete;
  logic                           w_take;
  logic                           w_timeout;

  assign w_complete = &r_pending;

  always_comb begin
    w_frame = '0;
    for (int k = 0; k < NUM_RX; k++) begin
      w_frame[(2*k)*DATA_WIDTH +: DATA_WIDTH]   = r_left[k*DATA_WIDTH +: DATA_WIDTH];
      w_frame[(2*k+1)*DATA_WIDTH +: DATA_WIDTH] = r_right[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // A strobe on the transfer or flush edge starts the next frame instead of overrunning.
  always_comb begin
    w_ovr_sum = 16'(r_overrun) + 16'(w_timeout);
    for (int k = 0; k < NUM_RX; k++) begin
      if (rx_valid[k] && r_pending[k] && !w_take && !w_timeout) begin
        w_ovr_sum = w_ovr_sum + 16'd1;
      end
    end
    if (w_take || w_timeout) begin
      w_pending_d = rx_valid;
    end else begin
      w_pending_d = r_pending | rx_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_left    <= '0;
      r_right   <= '0;
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      r_pending <= w_pending_d;
      r_overrun <= (w_ovr_sum > 16'(2**OverrunCountWidth - 1)) ?
                   {OverrunCountWidth{1'b1}} : w_ovr_sum[OverrunCountWidth-1:0];
      for (int k = 0; k < NUM_RX; k++) begin
        if (rx_valid[k]) begin
          r_left[k*DATA_WIDTH +: DATA_WIDTH]  <= rx_left[k*DATA_WIDTH +: DATA_WIDTH];
          r_right[k*DATA_WIDTH +: DATA_WIDTH] <= rx_right[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

`ifdef MIC_SEQ_SKEW_TIMEOUT_EN
  localparam int unsigned SkewWidth = $clog2(SKEW_TIMEOUT + 1);

  logic [SkewWidth-1:0] r_skew_cnt;
  logic                 r_skew_err;

  // Counts only while a frame is partially captured; a complete frame waiting is exempt.
  assign w_timeout = (r_pending != '0) && !w_complete &&
                     (r_skew_cnt == SkewWidth'(SKEW_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skew_cnt <= '0;
      r_skew_err <= 1'b0;
    end else begin
      if (w_take || w_timeout) begin
        r_skew_cnt <= '0;
      end else if ((r_pending != '0) && !w_complete) begin
        r_skew_cnt <= r_skew_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_skew_err <= 1'b1;
      end
    end
  end

  assign skew_err = r_skew_err;
`else
  assign w_timeout = 1'b0;
  assign skew_err  = 1'b0;
`endif

  mic_seq_serializer #(
    .NumChan   (NumChan),
    .DataWidth (DATA_WIDTH),
    .ChanWidth (ChanWidth)
  ) u_serializer (
    .clk           (clk),
    .rst           (rst),
    .i_frame_valid (w_complete),
    .i_frame       (w_frame),
    .o_take        (w_take),
    .o_data        (out_data),
    .o_chan        (out_chan),
    .o_valid       (out_valid),
    .i_ready       (out_ready),
    .o_last        (out_last),
    .o_frame_count (frame_count)
  );

  assign overrun_count = r_overrun;

endmodule

// File: tb/tb_mic_frame_sequencer.sv
// Scoreboard bench for mic_frame_sequencer: directed frames, stalls, overrun, skew, reset.
module tb_mic_frame_sequencer;

  localparam int unsigned NRX  = 4;
  localparam int unsigned DW   = 24;
  localparam int unsigned SKEW = 64;

  typedef struct packed {
    logic [2:0]    chan;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NRX-1:0]    rx_valid = '0;
  logic [NRX*DW-1:0] rx_left = '0;
  logic [NRX*DW-1:0] rx_right = '0;
  logic [DW-1:0]     out_data;
  logic [2:0]        out_chan;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [15:0]       frame_count;
  logic [7:0]        overrun_count;
  logic              skew_err;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  logic  toggle_mode = 1'b0;
  logic  prev_stall = 1'b0;
  beat_t saved_beat;

  always #5 clk = ~clk;

  mic_frame_sequencer #(
    .NUM_RX       (NRX),
    .DATA_WIDTH   (DW),
    .SKEW_TIMEOUT (SKEW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_valid      (rx_valid),
    .rx_left       (rx_left),
    .rx_right      (rx_right),
    .out_data      (out_data),
    .out_chan      (out_chan),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .frame_count   (frame_count),
    .overrun_count (overrun_count),
    .skew_err      (skew_err)
  );

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = toggle_mode ? ~out_ready : 1'b1;
    end
  end

  // Monitor: pops expected beats on each handshake and checks hold during stalls.
  always @(negedge clk) begin
    beat_t cur;
    beat_t e;
    cur = '{chan: out_chan, data: out_data, last: out_last};
    if (prev_stall) begin
      checks++;
      if (!out_valid || cur !== saved_beat) begin
        errors++;
        $display("FAIL stall_hold got v=%0b %h expected v=1 %h", out_valid, cur, saved_beat);
      end
    end
    prev_stall = out_valid && !out_ready && !rst;
    saved_beat = cur;
    if (out_valid && out_ready && !rst) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat got chan=%0d data=%h expected no beat", out_chan, out_data);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e) begin
          errors++;
          $display("FAIL beat got chan=%0d data=%h last=%0b expected chan=%0d data=%h last=%0b",
                   cur.chan, cur.data, cur.last, e.chan, e.data, e.last);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic [NRX-1:0] mask, input logic [DW-1:0] lbase,
                        input logic [DW-1:0] rbase);
    for (int k = 0; k < NRX; k++) begin
      if (mask[k]) begin
        rx_left[k*DW +: DW]  = lbase + DW'(k);
        rx_right[k*DW +: DW] = rbase + DW'(k);
      end
    end
    rx_valid = mask;
    tick(1);
    rx_valid = '0;
  endtask

  task automatic push_frame(input logic [DW-1:0] lbase, input logic [DW-1:0] rbase,
                            input int ovr_k, input logic [DW-1:0] ovr_l,
                            input logic [DW-1:0] ovr_r);
    beat_t b;
    for (int k = 0; k < NRX; k++) begin
      b.chan = 3'(2*k);
      b.data = (k == ovr_k) ? ovr_l : lbase + DW'(k);
      b.last = 1'b0;
      exp_q.push_back(b);
      b.chan = 3'(2*k + 1);
      b.data = (k == ovr_k) ? ovr_r : rbase + DW'(k);
      b.last = (k == NRX - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic skewed_frame(input logic [DW-1:0] lbase, input logic [DW-1:0] rbase);
    strobe(4'b0001, lbase, rbase);
    tick(2);
    strobe(4'b0010, lbase, rbase);
    tick(2);
    strobe(4'b0100, lbase, rbase);
    tick(2);
    strobe(4'b1000, lbase, rbase);
  endtask

  task automatic wait_drain(input string name);
    int i;
    for (i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      tick(1);
    end
    if (i == 300) begin
      checks++;
      errors++;
      $display("FAIL %s_drain got %0d beats left expected 0", name, exp_q.size());
    end
  endtask

  initial begin
    int n;
    int i;
    tick(3);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_chan", 32'(out_chan), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_overrun", 32'(overrun_count), 32'd0);
    chk("rst_skew_err", 32'(skew_err), 32'd0);
    rst = 1'b0;
    tick(2);

    // Skewed frame, ready held high; first beat two edges after the last strobe.
    push_frame(24'h100, 24'h200, -1, '0, '0);
    skewed_frame(24'h100, 24'h200);
    chk("latency_e0_valid", 32'(out_valid), 32'd0);
    tick(1);
    chk("latency_e1_valid", 32'(out_valid), 32'd1);
    wait_drain("basic");
    chk("basic_frame_count", 32'(frame_count), 32'd1);

    // Same frame with out_ready toggling.
    toggle_mode = 1'b1;
    push_frame(24'h100, 24'h200, -1, '0, '0);
    skewed_frame(24'h100, 24'h200);
    wait_drain("stall");
    toggle_mode = 1'b0;
    tick(2);
    chk("stall_frame_count", 32'(frame_count), 32'd2);

    // Receiver 2 strobes twice before receiver 3.
    push_frame(24'h100, 24'h200, 2, 24'h1F2, 24'h2F2);
    strobe(4'b0001, 24'h100, 24'h200);
    tick(1);
    strobe(4'b0010, 24'h100, 24'h200);
    tick(1);
    strobe(4'b0100, 24'h100, 24'h200);
    tick(1);
    strobe(4'b0100, 24'h1F0, 24'h2F0);
    tick(1);
    strobe(4'b1000, 24'h100, 24'h200);
    wait_drain("overrun");
    chk("overrun_count", 32'(overrun_count), 32'd1);
    chk("overrun_frame_count", 32'(frame_count), 32'd3);

    // Receiver 3 silent.
    strobe(4'b0001, 24'h100, 24'h200);
    tick(2);
    strobe(4'b0010, 24'h100, 24'h200);
    tick(2);
    strobe(4'b0100, 24'h100, 24'h200);
    tick(70);
    chk("silent_out_valid", 32'(out_valid), 32'd0);
`ifdef MIC_SEQ_SKEW_TIMEOUT_EN
    chk("skew_err_set", 32'(skew_err), 32'd1);
    chk("skew_overrun", 32'(overrun_count), 32'd2);
    push_frame(24'h100, 24'h200, -1, '0, '0);
    skewed_frame(24'h100, 24'h200);
    wait_drain("after_skew");
    chk("skew_err_sticky", 32'(skew_err), 32'd1);
`else
    chk("skew_err_tied", 32'(skew_err), 32'd0);
    chk("skew_overrun", 32'(overrun_count), 32'd1);
    push_frame(24'h100, 24'h200, -1, '0, '0);
    strobe(4'b1000, 24'h100, 24'h200);
    wait_drain("late_rx3");
`endif
    chk("after_skew_frame_count", 32'(frame_count), 32'd4);

    // Reset while chan 3 of a frame is presented.
    push_frame(24'h100, 24'h200, -1, '0, '0);
    strobe(4'b1111, 24'h100, 24'h200);
    for (i = 0; i < 20; i++) begin
      if (out_valid && out_chan == 3'd3) break;
      tick(1);
    end
    chk("reach_beat3", 32'(i < 20), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_out_chan", 32'(out_chan), 32'd0);
    chk("midrst_out_last", 32'(out_last), 32'd0);
    chk("midrst_frame_count", 32'(frame_count), 32'd0);
    chk("midrst_overrun", 32'(overrun_count), 32'd0);
    chk("midrst_skew_err", 32'(skew_err), 32'd0);
    @(posedge clk);
    #1;
    tick(1);
    rst = 1'b0;
    tick(1);

    // Two frames; the second strobes on the first's transfer edge.
    push_frame(24'h100, 24'h200, -1, '0, '0);
    push_frame(24'h300, 24'h400, -1, '0, '0);
    strobe(4'b1111, 24'h100, 24'h200);
    strobe(4'b1111, 24'h300, 24'h400);
    for (i = 0; i < 20; i++) begin
      if (out_valid) break;
      tick(1);
    end
    n = 0;
    while (out_valid && n < 40) begin
      n++;
      tick(1);
    end
    chk("b2b_consecutive_beats", 32'(n), 32'd16);
    wait_drain("b2b");
    chk("b2b_frame_count", 32'(frame_count), 32'd2);
    chk("b2b_overrun", 32'(overrun_count), 32'd0);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mic_frame_sequencer.md
# mic_frame_sequencer

Aligns per-microphone-pair samples from `NUM_RX` parallel I2S receivers into coherent array frames and streams each frame out one channel at a time to the MVDR beamformer front end. Sits between the `i2s_rx` instances (one `valid` pulse per stereo sample) and the covariance/weighting pipeline. Captures independently, double-buffers completed frames and serializes them on a ready/valid stream. Reports overrun and skew errors.

## Interface
Parameters:
- `NUM_RX`, 4: number of `i2s_rx` instances; each supplies 2 channels.
- `DATA_WIDTH`, 24: sample width.
- `SKEW_TIMEOUT`, 64: `clk` cycles allowed between the first and last receiver sample of one frame.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_valid`  in  NUM_RX  per-receiver one-cycle sample strobe.
- `rx_left`  in  NUM_RX*DATA_WIDTH  left samples; receiver k in bits [k*DW +: DW].
- `rx_right`  in  NUM_RX*DATA_WIDTH  right samples, same packing.
- `out_data`  out  DATA_WIDTH  current channel sample.
- `out_chan`  out  $clog2(2*NUM_RX)  channel index: 2k = rx k left, 2k+1 = rx k right.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready.
- `out_last`  out  1  high with the final channel of a frame.
- `frame_count`  out  16  completed frames emitted; wraps.
- `overrun_count`  out  8  dropped samples/frames; saturates at 255.
- `skew_err`  out  1  sticky; set on skew timeout; cleared only by `rst`.

## Operation
- Capture: on `rx_valid[k]`, register both samples into capture slot k and set `pending[k]`.
- Repeat valid on a receiver with `pending[k]` already set: overwrite the slot with the new sample and increment `overrun_count`.
- Frame complete when `pending` is all ones:
  - Serializer in IDLE: copy all slots into the output buffer, clear `pending`, enter SEND with `out_chan` = 0.
  - Serializer in SEND: hold the frame in capture; treat further valids per the overrun rule.
- Serializer states:
  - IDLE -> SEND on frame transfer.
  - In SEND, each `out_valid && out_ready` advances `out_chan`.
  - On the beat with `out_last`: increment `frame_count` and go to IDLE, or go straight back to SEND with `out_chan` = 0 if a complete frame is already waiting. Back-to-back frames have no idle cycle.
- Stream rules: `out_data`, `out_chan` and `out_last` are stable while `out_valid && !out_ready`. `out_valid` never drops without a handshake.
- Simultaneous events:
  - `rx_valid[k]` on the transfer edge: the new sample lands in slot k and `pending[k]` stays set for the next frame. Set wins over clear.
  - Overrun and transfer on the same edge: the new sample goes to the next frame, with no overrun.
- Reset, including mid-frame: all pending bits, buffers, counters and `skew_err` cleared; serializer to IDLE. A partially sent frame is discarded.

## Timing
- Reset values: `out_data` 0, `out_chan` 0, `out_valid` 0, `out_last` 0, `frame_count` 0, `overrun_count` 0, `skew_err` 0.
- Latency: the last `rx_valid` is sampled at edge E0. Transfer happens at E1 (serializer IDLE). `out_valid` is high after E1, so the first beat is 2 cycles after the strobe edge.
- Throughput: 1 channel per cycle with `out_ready` held high, i.e. 2*NUM_RX cycles per frame.
- Skew counter: starts on the first pending bit set from empty and clears on transfer. On reaching `SKEW_TIMEOUT` with the frame incomplete:
  - clear `pending`;
  - set `skew_err`;
  - increment `overrun_count` once.

## Configuration
- `MIC_SEQ_SKEW_TIMEOUT_EN` defined: the skew counter and timeout flush are built as described.
- Not defined: there is no counter and `skew_err` is tied to 0. An incomplete frame waits indefinitely; only the overwrite rule applies.

## Structure
- Package `mic_seq_pkg` holds:
  - serializer state enum (IDLE, SEND);
  - counter widths (16 and 8);
  - the channel-index width function.
- Sub-module `mic_seq_serializer` holds the output buffer, the IDLE/SEND FSM and the stream handshake. The top level holds capture, pending and skew logic.

## Test plan
- NUM_RX=4, receivers k strobe left=0x100+k and right=0x200+k, skewed over 10 cycles, `out_ready`=1. Expect 8 beats with chan 0..7 and data 0x100,0x200,0x101,…,0x203, `out_last` on chan 7, and `frame_count`=1.
- Same frame with `out_ready` toggling every other cycle: data and chan held during stalls, no beats lost or duplicated.
- Receiver 2 strobes twice before receiver 3 strobes: frame carries the second rx2 sample and `overrun_count`=1.
- Macro defined, SKEW_TIMEOUT=64, receiver 3 silent: after 64 cycles `skew_err`=1, `pending` cleared, no output. The next full frame emits normally.
- Assert `rst` at beat 3 of a frame: all outputs return to 0 next cycle and the next full frame starts at chan 0.
- Two frames completing with `out_ready`=1: 16 consecutive beats, no idle cycle, and `frame_count`=2.
